// File: rtl/disp_mux_7seg_if.sv
// ---------------------------------------------------------------------------
// disp_mux_7seg_if
// Bundle of the display controller's data/control inputs and its LED drive
// outputs.
//   digits_i  4*N_DIG  nibble k = hex code of digit k (digit 0 = rightmost)
//   dp_i      N_DIG    decimal point of digit k, active high
//   en_i      1        display enable
//   bright_i  4        brightness 0 (dimmest) .. 15 (full)
//   lz_sup_i  1        leading-zero suppression enable
//   anodo_o   N_DIG    active-low digit select
//   catodo_o  8        active-low segments {dp,g,f,e,d,c,b,a}
//   frame_o   1        one-cycle pulse at the end of each full scan
// master: the side that drives the inputs; slave: the display controller.
// ---------------------------------------------------------------------------
interface disp_mux_7seg_if #(
    parameter int N_DIG = 4
);
    logic [4*N_DIG-1:0] digits_i;
    logic [N_DIG-1:0]   dp_i;
    logic               en_i;
    logic [3:0]         bright_i;
    logic               lz_sup_i;
    logic [N_DIG-1:0]   anodo_o;
    logic [7:0]         catodo_o;
    logic               frame_o;

    modport master (
        output digits_i, dp_i, en_i, bright_i, lz_sup_i,
        input  anodo_o, catodo_o, frame_o
    );

    modport slave (
        input  digits_i, dp_i, en_i, bright_i, lz_sup_i,
        output anodo_o, catodo_o, frame_o
    );
endinterface

// File: rtl/disp_mux_7seg.sv
// ---------------------------------------------------------------------------
// disp_mux_7seg
// Time-multiplexed driver for an N_DIG-digit common-anode 7-segment display.
// Each digit owns a slot of PRESC clocks. The first BLANK_CYC clocks of a
// slot keep all anodes off (anti-ghosting); the slot is further divided into
// 16 slices and only slices 0..bright_i are lit (PWM brightness).
// Digit codes and decimal points are captured into shadow registers once
// per frame so a scan never shows a mix of old and new values.
// Ports:
//   clk_i    rising-edge clock
//   rst_n_i  asynchronous active-low reset
//   bus      disp_mux_7seg_if.slave (inputs and registered LED outputs)
// ---------------------------------------------------------------------------
module disp_mux_7seg #(
    parameter int N_DIG     = 4,
    parameter int PRESC     = 65536,
    parameter int BLANK_CYC = 64
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    disp_mux_7seg_if.slave  bus
);

    localparam int PW    = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam int IW    = (N_DIG > 1) ? $clog2(N_DIG) : 1;
    localparam int SLICE = PRESC / 16;

    localparam logic [PW-1:0] PCNT_MAX  = PW'(PRESC - 1);
    localparam logic [IW-1:0] IDX_MAX   = IW'(N_DIG - 1);
    localparam logic [PW-1:0] BLANK_END = PW'(BLANK_CYC);
    localparam logic [PW-1:0] SLICE_LEN = PW'(SLICE);

    // Segment pattern {g,f,e,d,c,b,a}, active low. Code F is a blank digit.
    function automatic logic [6:0] seg7(input logic [3:0] code);
        logic [6:0] s;
        case (code)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    // ------------------------------------------------------------------
    // Scan counters
    // ------------------------------------------------------------------
    logic [PW-1:0] pcnt_q, pcnt_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          end_slot;
    logic          end_frame;

    always_comb begin
        end_slot  = (pcnt_q == PCNT_MAX);
        end_frame = end_slot && (idx_q == IDX_MAX);
        pcnt_d    = end_slot ? '0 : pcnt_q + 1'b1;
        idx_d     = idx_q;
        if (end_slot) begin
            idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pcnt_q <= '0;
            idx_q  <= '0;
        end else begin
            pcnt_q <= pcnt_d;
            idx_q  <= idx_d;
        end
    end

    // ------------------------------------------------------------------
    // Shadow registers: loaded on the first clock after reset release and
    // at every end of frame.
    // ------------------------------------------------------------------
    logic             first_q;
    logic             load_en;
    logic [3:0]       dig_sh_q [N_DIG];
    logic [N_DIG-1:0] dp_sh_q;

    assign load_en = first_q || end_frame;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            first_q <= 1'b1;
            dp_sh_q <= '0;
        end else begin
            first_q <= 1'b0;
            if (load_en) begin
                dp_sh_q <= bus.dp_i;
            end
        end
    end

    // zero_hi[k] is set when shadow digits k..N_DIG-1 are all zero.
    logic [N_DIG:0] zero_hi;
    assign zero_hi[N_DIG] = 1'b1;

    generate
        for (genvar gi = 0; gi < N_DIG; gi++) begin : g_digit
            always_ff @(posedge clk_i or negedge rst_n_i) begin
                if (!rst_n_i) begin
                    dig_sh_q[gi] <= 4'hF;
                end else if (load_en) begin
                    dig_sh_q[gi] <= bus.digits_i[4*gi +: 4];
                end
            end

            assign zero_hi[gi] = zero_hi[gi+1] && (dig_sh_q[gi] == 4'h0);
        end
    endgenerate

    // ------------------------------------------------------------------
    // Output decode
    // ------------------------------------------------------------------
    logic [3:0]       sel_code;
    logic             sel_dp;
    logic             sel_lead_zero;
    logic [N_DIG-1:0] anode_hit;
    logic [PW-1:0]    slice;
    logic             active;
    logic [N_DIG-1:0] anodo_q, anodo_d;
    logic [7:0]       catodo_q, catodo_d;
    logic             frame_q;

    always_comb begin
        sel_code      = 4'hF;
        sel_dp        = 1'b0;
        sel_lead_zero = 1'b0;
        anode_hit     = '0;
        for (int k = 0; k < N_DIG; k++) begin
            if (idx_q == IW'(k)) begin
                sel_code      = dig_sh_q[k];
                sel_dp        = dp_sh_q[k];
                // Digit 0 is never treated as a leading zero.
                sel_lead_zero = (k != 0) && zero_hi[k];
                anode_hit[k]  = 1'b1;
            end
        end

        slice  = pcnt_q / SLICE_LEN;
        active = bus.en_i && (pcnt_q >= BLANK_END) && (slice <= PW'(bus.bright_i));

        anodo_d  = '1;
        catodo_d = 8'hFF;
        if (active) begin
            anodo_d = ~anode_hit;
            // A suppressed leading zero keeps its anode and decimal point.
            catodo_d = {~sel_dp, (bus.lz_sup_i && sel_lead_zero) ? 7'h7F : seg7(sel_code)};
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            anodo_q  <= '1;
            catodo_q <= 8'hFF;
            frame_q  <= 1'b0;
        end else begin
            anodo_q  <= anodo_d;
            catodo_q <= catodo_d;
            frame_q  <= end_frame;
        end
    end

    assign bus.anodo_o  = anodo_q;
    assign bus.catodo_o = catodo_q;
    assign bus.frame_o  = frame_q;

endmodule
